rv32i_mc_controller: RTL and testbench
======================================

# rv32i_mc_controller

Multi-cycle sequencing controller for the RV32I core. It replaces the single-cycle combinational control path with a Moore state machine that steps one instruction through fetch, decode, execute, memory and writeback over 3–5 cycles. Its strobes drive a datapath with IR/OldPC/ALUOut/Data registers and one shared instruction/data memory port. It also stalls on a memory-ready handshake.

## Interface
- Parameters: none.
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  7  IR[6:0], from the datapath instruction register.
- funct3  in  3  IR[14:12].
- funct7_5  in  1  IR[30].
- Zero  in  1  ALU result == 0, combinational from the datapath.
- mem_ready  in  1  shared memory completes the current access this cycle.
- PCWrite  out  1  load PC from Result.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  load IR and OldPC.
- RegWrite  out  1  register file write strobe.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 register (A).
- ALUSrcB  out  2  00 = rs2 register, 01 = ImmExt, 10 = constant 4.
- ImmSrc  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U. Decoded combinationally from opcode in every state.
- ALUControl  out  4  ALU operation code; encoding is defined in rv32i_pkg.
- illegal_instr  out  1  one-cycle pulse in DECODE when the opcode is unsupported.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWRITE, MEMWB, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, JALRADR, JALR, LUI, AUIPC.
- Default outputs: all strobes 0, all selects 0, ALUControl = ADD.
- FETCH: AdrSrc=0, A=00, B=10, ADD, ResultSrc=10.
  - IRWrite and PCWrite equal mem_ready.
  - Stay in FETCH while !mem_ready; go to DECODE when mem_ready.
- DECODE: A=01, B=01, ADD; the branch/JAL target is latched into ALUOut. Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALRADR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - any other opcode → FETCH, with illegal_instr=1.
- MEMADR: A=10, B=01, ADD. Go to MEMREAD if opcode[5]=0, otherwise MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Hold until mem_ready, then go to MEMWB.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. Hold (MemWrite stays high) until mem_ready, then go to FETCH.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- EXECUTER: A=10, B=00, ALUControl from the ALU decoder, then ALUWB.
- EXECUTEI: A=10, B=01. funct7_5 is honoured only for funct3=101 (SRAI/SRLI), so ADDI never becomes SUB. Then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: A=10, B=00, ResultSrc=00, then FETCH.
  - ALUControl: SUB for funct3 00x, SLT for 10x, SLTU for 11x.
  - PCWrite = Zero for BEQ/BGE/BGEU; PCWrite = !Zero for BNE/BLT/BLTU.
  - funct3 010/011 is illegal: no PCWrite, illegal_instr=1.
- JAL: A=01, B=10, ADD, ResultSrc=00, PCWrite=1, then ALUWB (rd ← OldPC+4).
- JALRADR: A=10, B=01, ADD, then JALR.
- JALR: A=01, B=10, ADD, ResultSrc=00, PCWrite=1, then ALUWB. The datapath clears PC bit 0.
- LUI: B=01, ALUControl=PASSB, then ALUWB.
- AUIPC: A=01, B=01, ADD, then ALUWB.

## Timing
- Reset: state=FETCH asynchronously.
  - While rst=1, PCWrite, IRWrite, RegWrite, MemWrite and illegal_instr are forced to 0.
  - All other outputs take the FETCH encoding.
- Reset mid-instruction aborts the instruction immediately; MemWrite drops in the same cycle.
- Cycles per instruction with mem_ready tied to 1:
  - branch 3
  - R/I-ALU, LUI, AUIPC, JAL, store 4
  - load, JALR 5
- Every cycle mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. Outputs are held stable while waiting.
- mem_ready is ignored in all other states.
- Outputs are Moore (state-derived). Exceptions: PCWrite/IRWrite in FETCH follow mem_ready, BRANCH PCWrite follows Zero, and ImmSrc follows opcode.

## Structure
- rv32i_pkg holds:
  - the state enum
  - opcode constants
  - ALUControl encoding: ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLT=0101, SLTU=0110, SLL=0111, SRL=1000, SRA=1001, PASSB=1010
  - the ResultSrc/ALUSrcA/ALUSrcB/ImmSrc select encodings.
- Sub-module: rv32i_alu_decoder, combinational (funct3, funct7_5, is_reg → ALUControl). The FSM overrides its output in non-execute states.

## Test plan
- add x3,x1,x2 (0x002081B3), mem_ready=1: states FETCH→DECODE→EXECUTER→ALUWB→FETCH. RegWrite only in cycle 4, ALUControl=0000 in EXECUTER.
- lw (0x0000A183) with mem_ready low for 2 cycles in MEMREAD: 7 cycles total, AdrSrc=1 held for 3 cycles, RegWrite=1 with ResultSrc=01 in MEMWB.
- sw (0x0020A023): MemWrite=1 for exactly one cycle, in MEMWRITE; no RegWrite; back to FETCH after 4 cycles.
- bne (funct3=001):
  - Zero=0: PCWrite=1 in BRANCH, ALUControl=0001.
  - Zero=1: PCWrite=0.
  - bgeu with Zero=1: PCWrite=1 and ALUControl=0110.
- jalr (0x000080E7): FETCH→DECODE→JALRADR→JALR→ALUWB, PCWrite in JALR, RegWrite in ALUWB. Opcode 0x7F: illegal_instr pulses in DECODE, next state FETCH.
- Assert rst during MEMWRITE: MemWrite falls in the same cycle, state=FETCH; after release, the first FETCH asserts IRWrite only when mem_ready=1.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared types and encodings for the RV32I multi-cycle control path.
// Select encodings match the datapath mux ordering.
package rv32i_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE, S_MEMWB,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_JAL, S_JALRADR,
    S_JALR, S_LUI, S_AUIPC
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLT   = 4'b0101,
    ALU_SLTU  = 4'b0110,
    ALU_SLL   = 4'b0111,
    ALU_SRL   = 4'b1000,
    ALU_SRA   = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_op_t;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10
  } src_a_t;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } src_b_t;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_t;

  // State-derived controls that are held in flops; strobes that follow
  // live inputs (mem_ready, Zero) are produced combinationally instead.
  typedef struct packed {
    logic        adr_src;
    logic        mem_write;
    logic        reg_write;
    result_src_t result_src;
    src_a_t      alu_src_a;
    src_b_t      alu_src_b;
    alu_op_t     alu_control;
  } ctrl_t;

  localparam ctrl_t CTRL_DEFAULT = '{
    adr_src: 1'b0, mem_write: 1'b0, reg_write: 1'b0,
    result_src: RES_ALUOUT, alu_src_a: SRCA_PC, alu_src_b: SRCB_RS2,
    alu_control: ALU_ADD
  };

  localparam ctrl_t CTRL_FETCH = '{
    adr_src: 1'b0, mem_write: 1'b0, reg_write: 1'b0,
    result_src: RES_ALURESULT, alu_src_a: SRCA_PC, alu_src_b: SRCB_FOUR,
    alu_control: ALU_ADD
  };

  function automatic logic opcode_legal(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  function automatic imm_src_t imm_src_for(input logic [6:0] op);
    case (op)
      OP_STORE:         return IMM_S;
      OP_BRANCH:        return IMM_B;
      OP_JAL:           return IMM_J;
      OP_LUI, OP_AUIPC: return IMM_U;
      default:          return IMM_I;
    endcase
  endfunction

  // Branch compare op: 00x equality via SUB, 10x signed, 11x unsigned.
  function automatic alu_op_t branch_alu_op(input logic [2:0] funct3);
    case (funct3[2:1])
      2'b10:   return ALU_SLT;
      2'b11:   return ALU_SLTU;
      default: return ALU_SUB;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_alu_decoder.sv
// Combinational ALU operation decode for R-type and I-type ALU instructions.
module rv32i_alu_decoder
  import rv32i_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       is_reg,
  output alu_op_t    alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (funct3)
      // IR[30] on I-type ADDI is immediate data, not a SUB select
      3'b000: alu_control = (is_reg && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001: alu_control = ALU_SLL;
      3'b010: alu_control = ALU_SLT;
      3'b011: alu_control = ALU_SLTU;
      3'b100: alu_control = ALU_XOR;
      3'b101: alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110: alu_control = ALU_OR;
      3'b111: alu_control = ALU_AND;
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/rv32i_mc_controller.sv
// Multi-cycle Moore sequencer for the RV32I core: steps one instruction
// through fetch/decode/execute/memory/writeback with a shared memory port.
module rv32i_mc_controller
  import rv32i_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       illegal_instr
);

  state_t  state_q, state_d;
  ctrl_t   ctrl_q, ctrl_d;
  alu_op_t dec_alu_op;
  logic    is_reg;
  logic    branch_bad, branch_taken;
  logic    pc_write, ir_write, illegal;

  // Decoder is evaluated for the state being entered, since ctrl is registered.
  assign is_reg = (state_d == S_EXECUTER);

  rv32i_alu_decoder u_alu_dec (
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .is_reg      (is_reg),
    .alu_control (dec_alu_op)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALRADR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_JALRADR:  state_d = S_JALR;
      S_EXECUTER, S_EXECUTEI, S_JAL, S_JALR, S_LUI, S_AUIPC:
                  state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl_d = CTRL_DEFAULT;
    case (state_d)
      S_FETCH: ctrl_d = CTRL_FETCH;
      S_DECODE: begin
        ctrl_d.alu_src_a = SRCA_OLDPC;
        ctrl_d.alu_src_b = SRCB_IMM;
      end
      S_MEMADR, S_JALRADR: begin
        ctrl_d.alu_src_a = SRCA_RS1;
        ctrl_d.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: ctrl_d.adr_src = 1'b1;
      S_MEMWRITE: begin
        ctrl_d.adr_src   = 1'b1;
        ctrl_d.mem_write = 1'b1;
      end
      S_MEMWB: begin
        ctrl_d.result_src = RES_DATA;
        ctrl_d.reg_write  = 1'b1;
      end
      S_EXECUTER: begin
        ctrl_d.alu_src_a   = SRCA_RS1;
        ctrl_d.alu_control = dec_alu_op;
      end
      S_EXECUTEI: begin
        ctrl_d.alu_src_a   = SRCA_RS1;
        ctrl_d.alu_src_b   = SRCB_IMM;
        ctrl_d.alu_control = dec_alu_op;
      end
      S_ALUWB: ctrl_d.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl_d.alu_src_a   = SRCA_RS1;
        ctrl_d.alu_control = branch_alu_op(funct3);
      end
      S_JAL, S_JALR: begin
        ctrl_d.alu_src_a = SRCA_OLDPC;
        ctrl_d.alu_src_b = SRCB_FOUR;
      end
      S_LUI: begin
        ctrl_d.alu_src_b   = SRCB_IMM;
        ctrl_d.alu_control = ALU_PASSB;
      end
      S_AUIPC: begin
        ctrl_d.alu_src_a = SRCA_OLDPC;
        ctrl_d.alu_src_b = SRCB_IMM;
      end
      default: ctrl_d = CTRL_DEFAULT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      ctrl_q  <= CTRL_FETCH;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Taken sense flips between 00x (equality) and 1xx (compare) groups and with funct3[0].
  assign branch_bad   = (funct3[2:1] == 2'b01);
  assign branch_taken = Zero ^ funct3[0] ^ funct3[2];

  always_comb begin
    pc_write = 1'b0;
    ir_write = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        pc_write = mem_ready;
        ir_write = mem_ready;
      end
      S_DECODE: illegal = ~opcode_legal(opcode);
      S_BRANCH: begin
        pc_write = branch_taken & ~branch_bad;
        illegal  = branch_bad;
      end
      S_JAL, S_JALR: pc_write = 1'b1;
      default: ;
    endcase
  end

  assign PCWrite       = pc_write & ~rst;
  assign IRWrite       = ir_write & ~rst;
  assign illegal_instr = illegal & ~rst;
  assign RegWrite      = ctrl_q.reg_write & ~rst;
  assign MemWrite      = ctrl_q.mem_write & ~rst;
  assign AdrSrc        = ctrl_q.adr_src;
  assign ResultSrc     = ctrl_q.result_src;
  assign ALUSrcA       = ctrl_q.alu_src_a;
  assign ALUSrcB       = ctrl_q.alu_src_b;
  assign ALUControl    = ctrl_q.alu_control;
  assign ImmSrc        = imm_src_for(opcode);

endmodule

// File: tb/tb_rv32i_mc_controller.sv
// Self-checking bench for rv32i_mc_controller: decode table, hand-written
// multi-cycle sequences, and randomized instructions against a step model.
module tb_rv32i_mc_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5, Zero, mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;

  rv32i_mc_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
    .funct7_5(funct7_5), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Per-cycle samples and per-instruction strobe tallies.
  logic s_pcw, s_irw, s_rw, s_mw, s_ill, s_adr, s_fetch;
  logic [1:0] s_res;
  logic [3:0] s_alu;
  logic [2:0] s_imm;
  int cnt_pcw, cnt_irw, cnt_rw, cnt_mw, cnt_ill, cnt_adr, ncyc;

  task automatic clr();
    cnt_pcw = 0; cnt_irw = 0; cnt_rw = 0; cnt_mw = 0;
    cnt_ill = 0; cnt_adr = 0; ncyc = 0;
  endtask

  function automatic logic fetch_sig();
    return (AdrSrc == 1'b0) && (ALUSrcA == 2'b00) && (ALUSrcB == 2'b10) &&
           (ResultSrc == 2'b10) && (ALUControl == 4'b0000);
  endfunction

  // Called at posedge+1: drive mem_ready, sample at negedge, return at next posedge+1.
  task automatic cyc(input logic mr);
    mem_ready = mr;
    @(negedge clk);
    s_pcw = PCWrite; s_irw = IRWrite; s_rw = RegWrite; s_mw = MemWrite;
    s_ill = illegal_instr; s_adr = AdrSrc; s_res = ResultSrc;
    s_alu = ALUControl; s_imm = ImmSrc; s_fetch = fetch_sig();
    cnt_pcw += int'(PCWrite); cnt_irw += int'(IRWrite);
    cnt_rw  += int'(RegWrite); cnt_mw += int'(MemWrite);
    cnt_ill += int'(illegal_instr); cnt_adr += int'(AdrSrc);
    ncyc++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic z);
    opcode = op; funct3 = f3; funct7_5 = f7; Zero = z;
  endtask

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    logic [3:0] alu3;
    logic [2:0] imm;
    logic       pcw3;
    int         ncyc;
  } vec_t;

  vec_t vecs[$];

  // Reference model: branch outcome straight from the ISA mnemonics.
  function automatic logic ref_taken(input logic [2:0] f3, input logic z);
    case (f3)
      3'b000: return z;   // BEQ
      3'b001: return !z;  // BNE
      3'b100: return !z;  // BLT  (SLT result nonzero)
      3'b101: return z;   // BGE
      3'b110: return !z;  // BLTU
      3'b111: return z;   // BGEU
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    set_instr(7'b0110011, 3'b000, 1'b0, 1'b0);
    mem_ready = 1'b1;

    // Reset state: strobes forced low even with mem_ready high, FETCH selects.
    #12;
    check("rst_irwrite", IRWrite, 0);
    check("rst_pcwrite", PCWrite, 0);
    check("rst_regwrite", RegWrite, 0);
    check("rst_memwrite", MemWrite, 0);
    check("rst_fetch_sig", fetch_sig(), 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // ---------------- decode table ----------------
    vecs.push_back('{"add",   7'b0110011, 3'b000, 1'b0, 1'b0, 4'b0000, 3'b000, 1'b0, 4});
    vecs.push_back('{"sub",   7'b0110011, 3'b000, 1'b1, 1'b0, 4'b0001, 3'b000, 1'b0, 4});
    vecs.push_back('{"sra",   7'b0110011, 3'b101, 1'b1, 1'b0, 4'b1001, 3'b000, 1'b0, 4});
    vecs.push_back('{"srl",   7'b0110011, 3'b101, 1'b0, 1'b0, 4'b1000, 3'b000, 1'b0, 4});
    vecs.push_back('{"sltu",  7'b0110011, 3'b011, 1'b0, 1'b0, 4'b0110, 3'b000, 1'b0, 4});
    vecs.push_back('{"and",   7'b0110011, 3'b111, 1'b0, 1'b0, 4'b0010, 3'b000, 1'b0, 4});
    vecs.push_back('{"sll",   7'b0110011, 3'b001, 1'b0, 1'b0, 4'b0111, 3'b000, 1'b0, 4});
    vecs.push_back('{"addi7", 7'b0010011, 3'b000, 1'b1, 1'b0, 4'b0000, 3'b000, 1'b0, 4});
    vecs.push_back('{"srai",  7'b0010011, 3'b101, 1'b1, 1'b0, 4'b1001, 3'b000, 1'b0, 4});
    vecs.push_back('{"xori",  7'b0010011, 3'b100, 1'b0, 1'b0, 4'b0100, 3'b000, 1'b0, 4});
    vecs.push_back('{"ori",   7'b0010011, 3'b110, 1'b1, 1'b0, 4'b0011, 3'b000, 1'b0, 4});
    vecs.push_back('{"bne_z0",7'b1100011, 3'b001, 1'b0, 1'b0, 4'b0001, 3'b010, 1'b1, 3});
    vecs.push_back('{"bne_z1",7'b1100011, 3'b001, 1'b0, 1'b1, 4'b0001, 3'b010, 1'b0, 3});
    vecs.push_back('{"beq_z1",7'b1100011, 3'b000, 1'b0, 1'b1, 4'b0001, 3'b010, 1'b1, 3});
    vecs.push_back('{"bgeu",  7'b1100011, 3'b111, 1'b0, 1'b1, 4'b0110, 3'b010, 1'b1, 3});
    vecs.push_back('{"blt",   7'b1100011, 3'b100, 1'b0, 1'b0, 4'b0101, 3'b010, 1'b1, 3});
    vecs.push_back('{"bge_z0",7'b1100011, 3'b101, 1'b1, 1'b0, 4'b0101, 3'b010, 1'b0, 3});
    vecs.push_back('{"lui",   7'b0110111, 3'b010, 1'b0, 1'b0, 4'b1010, 3'b100, 1'b0, 4});
    vecs.push_back('{"auipc", 7'b0010111, 3'b101, 1'b1, 1'b0, 4'b0000, 3'b100, 1'b0, 4});
    vecs.push_back('{"jal",   7'b1101111, 3'b000, 1'b0, 1'b0, 4'b0000, 3'b011, 1'b1, 4});
    vecs.push_back('{"jalr",  7'b1100111, 3'b000, 1'b0, 1'b0, 4'b0000, 3'b000, 1'b0, 5});
    vecs.push_back('{"lw",    7'b0000011, 3'b010, 1'b0, 1'b0, 4'b0000, 3'b000, 1'b0, 5});
    vecs.push_back('{"sw",    7'b0100011, 3'b010, 1'b0, 1'b0, 4'b0000, 3'b001, 1'b0, 4});

    foreach (vecs[i]) begin
      logic [3:0] alu3;
      logic [2:0] imm3;
      logic       pcw3;
      alu3 = 4'h0; imm3 = 3'h0; pcw3 = 1'b0;
      set_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z);
      clr();
      for (int c = 1; c <= vecs[i].ncyc; c++) begin
        cyc(1'b1);
        if (c == 1) check({vecs[i].name, "_starts_in_fetch"}, s_fetch & s_irw, 1);
        if (c == 3) begin alu3 = s_alu; imm3 = s_imm; pcw3 = s_pcw; end
      end
      check({vecs[i].name, "_alucontrol"}, alu3, vecs[i].alu3);
      check({vecs[i].name, "_immsrc"}, imm3, vecs[i].imm);
      check({vecs[i].name, "_pcwrite_c3"}, pcw3, vecs[i].pcw3);
      check({vecs[i].name, "_irwrite_cnt"}, cnt_irw, 1);
    end
    set_instr(7'b0110011, 3'b000, 1'b0, 1'b0);
    cyc(1'b1);
    check("table_end_fetch", s_fetch & s_irw, 1);

    // ---------------- lw with two MEMREAD stalls ----------------
    do_reset();
    set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
    clr();
    begin
      logic mr_seq [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      int rw_at = 0;
      for (int c = 0; c < 7; c++) begin
        cyc(mr_seq[c]);
        if (s_rw && s_res == 2'b01) rw_at = c + 1;
      end
      check("lw_adrsrc_cycles", cnt_adr, 3);
      check("lw_regwrite_memwb_cycle", rw_at, 7);
      check("lw_regwrite_cnt", cnt_rw, 1);
    end
    cyc(1'b1);
    check("lw_back_to_fetch", s_fetch & s_irw, 1);

    // ---------------- sw ----------------
    do_reset();
    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
    clr();
    begin
      int mw_at = 0;
      for (int c = 1; c <= 4; c++) begin
        cyc(1'b1);
        if (s_mw) mw_at = c;
      end
      check("sw_memwrite_cnt", cnt_mw, 1);
      check("sw_memwrite_cycle", mw_at, 4);
      check("sw_no_regwrite", cnt_rw, 0);
    end
    cyc(1'b1);
    check("sw_back_to_fetch", s_fetch & s_irw, 1);

    // ---------------- jalr ----------------
    do_reset();
    set_instr(7'b1100111, 3'b000, 1'b0, 1'b0);
    clr();
    begin
      int pcw_at = 0, rw_at = 0;
      for (int c = 1; c <= 5; c++) begin
        cyc(1'b1);
        if (s_pcw && c > 1) pcw_at = c;
        if (s_rw) rw_at = c;
      end
      check("jalr_pcwrite_cycle", pcw_at, 4);
      check("jalr_regwrite_cycle", rw_at, 5);
      check("jalr_pcwrite_cnt", cnt_pcw, 2);
    end
    cyc(1'b1);
    check("jalr_back_to_fetch", s_fetch & s_irw, 1);

    // ---------------- illegal opcode 0x7F ----------------
    do_reset();
    set_instr(7'h7F, 3'b000, 1'b0, 1'b0);
    clr();
    cyc(1'b1);
    check("ill_not_in_fetch", s_ill, 0);
    cyc(1'b1);
    check("ill_pulse_decode", s_ill, 1);
    cyc(1'b1);
    check("ill_next_fetch", s_fetch & s_irw, 1);
    check("ill_pulse_cnt", cnt_ill, 1);

    // ---------------- illegal branch funct3 ----------------
    do_reset();
    set_instr(7'b1100011, 3'b011, 1'b0, 1'b0);
    clr();
    for (int c = 0; c < 3; c++) cyc(1'b1);
    check("bill_pcwrite_cnt", cnt_pcw, 1);
    check("bill_illegal_cnt", cnt_ill, 1);
    cyc(1'b1);
    check("bill_back_to_fetch", s_fetch & s_irw, 1);

    // ---------------- reset during MEMWRITE ----------------
    do_reset();
    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
    cyc(1'b1); cyc(1'b1); cyc(1'b1);
    mem_ready = 1'b0;
    @(negedge clk);
    check("rstmw_memwrite_before", MemWrite, 1);
    #2 rst = 1'b1;
    #1;
    check("rstmw_memwrite_drops", MemWrite, 0);
    check("rstmw_fetch_sig", fetch_sig(), 1);
    mem_ready = 1'b1;
    #1;
    check("rstmw_irwrite_forced", IRWrite, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1'b0);
    check("rstmw_fetch_wait_irw", s_irw, 0);
    check("rstmw_fetch_wait_sig", s_fetch, 1);
    cyc(1'b1);
    check("rstmw_fetch_ready_irw", s_irw, 1);

    // ---------------- randomized instructions vs step model ----------------
    do_reset();
    for (int n = 0; n < 250; n++) begin
      int          cls;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        f7, z;
      bit          waits[$];
      int          exp_pcw, exp_rw, exp_mw, exp_ill;
      logic [6:0]  bad_ops [4] = '{7'h7F, 7'h00, 7'b0001111, 7'b1110011};
      cls = $urandom_range(0, 9);
      f3  = 3'($urandom_range(0, 7));
      f7  = 1'($urandom_range(0, 1));
      z   = 1'($urandom_range(0, 1));
      exp_pcw = 1; exp_rw = 0; exp_mw = 0; exp_ill = 0;
      case (cls)
        0: begin op = 7'b0110011; waits = '{1, 0, 0, 0}; exp_rw = 1; end
        1: begin op = 7'b0010011; waits = '{1, 0, 0, 0}; exp_rw = 1; end
        2: begin op = 7'b0110111; waits = '{1, 0, 0, 0}; exp_rw = 1; end
        3: begin op = 7'b0010111; waits = '{1, 0, 0, 0}; exp_rw = 1; end
        4: begin op = 7'b1101111; waits = '{1, 0, 0, 0}; exp_rw = 1; exp_pcw++; end
        5: begin op = 7'b1100111; waits = '{1, 0, 0, 0, 0}; exp_rw = 1; exp_pcw++; end
        6: begin op = 7'b0000011; waits = '{1, 0, 0, 1, 0}; exp_rw = 1; end
        7: begin op = 7'b0100011; waits = '{1, 0, 0, 1}; end
        8: begin
          op = 7'b1100011; waits = '{1, 0, 0};
          if (f3 == 3'b010 || f3 == 3'b011) exp_ill = 1;
          else exp_pcw += int'(ref_taken(f3, z));
        end
        default: begin
          op = bad_ops[$urandom_range(0, 3)]; waits = '{1, 0}; exp_ill = 1;
        end
      endcase
      set_instr(op, f3, f7, z);
      clr();
      foreach (waits[k]) begin
        if (waits[k]) begin
          logic mr;
          int   tries = 0;
          do begin
            mr = (tries >= 6) ? 1'b1 : ($urandom_range(0, 2) != 0);
            cyc(mr);
            if (cls == 7 && k == 3) exp_mw++;
            if (ncyc == 1) check("rand_starts_in_fetch", s_fetch, 1);
            tries++;
          end while (!mr);
        end else begin
          cyc(1'($urandom_range(0, 1)));
        end
      end
      check("rand_pcwrite_cnt", cnt_pcw, exp_pcw);
      check("rand_irwrite_cnt", cnt_irw, 1);
      check("rand_regwrite_cnt", cnt_rw, exp_rw);
      check("rand_memwrite_cnt", cnt_mw, exp_mw);
      check("rand_illegal_cnt", cnt_ill, exp_ill);
    end
    cyc(1'b0);
    check("rand_end_fetch", s_fetch, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
